// File: rtl/pdm_multi.sv
// pdm_multi: multi-channel first/second-order pulse-density modulator with shared
// prescaler and double-buffered channel levels committed on a common step.
module pdm_multi #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int PRESCALE_BITS = 8,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [PRESCALE_BITS-1:0] prescale,
    input  logic                     wr_en,
    input  logic [CW-1:0]            wr_ch,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     update_req,
    output logic [CHANNELS-1:0]      pdm_out,
    output logic                     tick,
    output logic                     update_pending
);
    localparam int IW = WIDTH + 4;
    localparam int EW = WIDTH + 5;
    localparam logic signed [EW-1:0] SAT_HI = EW'((64'sd1 <<< (WIDTH + 2)) - 64'sd1);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-(64'sd1 <<< (WIDTH + 2)));
    localparam logic signed [EW-1:0] FB = EW'(64'sd1 <<< WIDTH);

    logic [PRESCALE_BITS-1:0] pcnt;
    logic                     mode_q;
    logic                     step;
    logic                     commit;
    logic [WIDTH-1:0]         shadow [CHANNELS];
    logic [WIDTH-1:0]         active [CHANNELS];
    logic [WIDTH-1:0]         acc [CHANNELS];
    logic signed [IW-1:0]     i1 [CHANNELS];
    logic signed [IW-1:0]     i2 [CHANNELS];
    logic signed [IW-1:0]     n1 [CHANNELS];
    logic signed [IW-1:0]     n2 [CHANNELS];
    logic [WIDTH:0]           sum [CHANNELS];
    logic [CHANNELS-1:0]      y;

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        return v > SAT_HI ? IW'(SAT_HI) : v < SAT_LO ? IW'(SAT_LO) : IW'(v);
    endfunction

    assign step = enable && pcnt == prescale;
    // A request arriving on a step cycle commits immediately.
    assign commit = step && (update_pending || update_req);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c] = {1'b0, active[c]} + {1'b0, acc[c]};
            y[c] = !i2[c][IW-1];
            n1[c] = sat(EW'(i1[c]) + EW'($signed({1'b0, active[c]})) - (y[c] ? FB : '0));
            n2[c] = sat(EW'(i2[c]) + EW'(n1[c]) - (y[c] ? FB : '0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            mode_q <= 1'b0;
            tick <= 1'b0;
            update_pending <= 1'b0;
            pdm_out <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= '0;
                active[c] <= '0;
                acc[c] <= '0;
                i1[c] <= '0;
                i2[c] <= '0;
            end
        end else begin
            pcnt <= (!enable || pcnt >= prescale) ? '0 : pcnt + 1'b1;
            tick <= step;
            update_pending <= !commit && (update_pending || update_req);
            mode_q <= mode;
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_en && wr_ch == CW'(c))
                    shadow[c] <= wr_data;
                if (commit)
                    active[c] <= shadow[c];
                if (!enable)
                    pdm_out[c] <= 1'b0;
                else if (step)
                    pdm_out[c] <= mode_q ? y[c] : sum[c][WIDTH];
                // A mode switch restarts the loop from a clean state.
                if (mode != mode_q) begin
                    acc[c] <= '0;
                    i1[c] <= '0;
                    i2[c] <= '0;
                end else if (step && mode_q) begin
                    i1[c] <= n1[c];
                    i2[c] <= n2[c];
                end else if (step) begin
                    acc[c] <= sum[c][WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_multi.sv
// tb_pdm_multi: table-driven density checks, hand sequences and randomized traffic
// against an integer reference model of pdm_multi.
module tb_pdm_multi;
    localparam int W = 8;
    localparam int C = 4;
    localparam int LIM = 1 << (W + 2);

    logic       clk = 0;
    logic       reset = 1;
    logic       enable = 0;
    logic       mode = 0;
    logic [7:0] prescale = 0;
    logic       wr_en = 0;
    logic [1:0] wr_ch = 0;
    logic [7:0] wr_data = 0;
    logic       update_req = 0;
    logic [3:0] pdm_out;
    logic       tick;
    logic       update_pending;

    int tests = 0;
    int fails = 0;

    pdm_multi #(.WIDTH(W), .CHANNELS(C), .PRESCALE_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .prescale(prescale),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .update_req(update_req),
        .pdm_out(pdm_out), .tick(tick), .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers following the modulator rules.
    int         m_pcnt, m_mode;
    int         m_shadow [C];
    int         m_active [C];
    int         m_acc [C];
    int         m_i1 [C];
    int         m_i2 [C];
    logic       m_tick, m_pend;
    logic [3:0] m_out;

    function automatic int msat(int v);
        return v > LIM - 1 ? LIM - 1 : v < -LIM ? -LIM : v;
    endfunction

    always @(posedge clk or posedge reset) begin : mdl
        bit st, cm;
        int s, yb, n1;
        if (reset) begin
            m_pcnt = 0; m_mode = 0; m_tick = 0; m_pend = 0; m_out = 0;
            for (int c = 0; c < C; c++) begin
                m_shadow[c] = 0; m_active[c] = 0; m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
            end
        end else begin
            st = enable && m_pcnt == int'(prescale);
            cm = st && (m_pend || update_req);
            m_pcnt = (!enable || m_pcnt >= int'(prescale)) ? 0 : m_pcnt + 1;
            m_tick = st;
            m_pend = !cm && (m_pend || update_req);
            for (int c = 0; c < C; c++) begin
                if (!enable) m_out[c] = 0;
                else if (st) begin
                    if (m_mode != 0) begin
                        yb = (m_i2[c] >= 0) ? 1 : 0;
                        n1 = msat(m_i1[c] + m_active[c] - 256 * yb);
                        m_i2[c] = msat(m_i2[c] + n1 - 256 * yb);
                        m_i1[c] = n1;
                        m_out[c] = yb[0];
                    end else begin
                        s = m_active[c] + m_acc[c];
                        m_out[c] = s >= 256;
                        m_acc[c] = s % 256;
                    end
                end
                if (int'(mode) != m_mode) begin
                    m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
                end
                if (cm) m_active[c] = m_shadow[c];
                if (wr_en && int'(wr_ch) == c) m_shadow[c] = int'(wr_data);
            end
            m_mode = int'(mode);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("pdm_out", 32'(pdm_out), 32'(m_out));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("update_pending", 32'(update_pending), 32'(m_pend));
    endtask

    int ones [C];
    bit seq0 [$];

    task automatic count_ticks(input int n);
        int t = 0, k = 0;
        for (int c = 0; c < C; c++) ones[c] = 0;
        seq0.delete();
        while (t < n && k < n * 10 + 20) begin
            cyc();
            k++;
            if (tick) begin
                t++;
                if (seq0.size() < 4) seq0.push_back(pdm_out[0]);
                for (int c = 0; c < C; c++) ones[c] += int'(pdm_out[c]);
            end
        end
        chk("tick_budget", t, n);
    endtask

    task automatic wr(input int ch, input int v);
        wr_en = 1; wr_ch = 2'(ch); wr_data = 8'(v);
        cyc();
        wr_en = 0;
    endtask

    task automatic commit_now();
        int k = 0;
        update_req = 1;
        cyc();
        update_req = 0;
        while (update_pending && k < 100) begin
            cyc();
            k++;
        end
        chk("commit_timeout", 32'(update_pending), 0);
    endtask

    typedef struct {
        int         ch;
        logic [7:0] lvl;
        int         exp_ones;
    } vec_t;
    vec_t tbl [4];

    initial begin
        int n, bad;
        logic [3:0] prev;
        tbl[0] = '{0, 8'h80, 128};
        tbl[1] = '{1, 8'h00, 0};
        tbl[2] = '{2, 8'hFF, 255};
        tbl[3] = '{3, 8'h01, 1};

        repeat (3) cyc();
        chk("reset_pdm_out", 32'(pdm_out), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_pending", 32'(update_pending), 0);
        reset = 0; enable = 1; prescale = 0;
        cyc();
        chk("first_tick", 32'(tick), 1);

        // Mode 0 densities over one full 256-step period.
        for (int i = 0; i < 4; i++) wr(tbl[i].ch, int'(tbl[i].lvl));
        commit_now();
        count_ticks(256);
        for (int i = 0; i < 4; i++) chk($sformatf("ones_ch%0d", tbl[i].ch), ones[tbl[i].ch], tbl[i].exp_ones);
        for (int i = 0; i < 4; i++) chk($sformatf("half_seq%0d", i), 32'(seq0[i]), 32'(i % 2));

        // Prescale 3: one step every 4 cycles, outputs move only on ticks.
        prescale = 3;
        n = 0; bad = 0; prev = pdm_out;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n += int'(tick);
            if (pdm_out != prev && !tick) bad++;
            prev = pdm_out;
        end
        chk("ps3_ticks", n, 10);
        chk("ps3_offtick_changes", bad, 0);
        enable = 0;
        cyc();
        chk("disable_low", 32'(pdm_out), 0);
        repeat (10) cyc();
        enable = 1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 20);
        chk("reenable_latency", n, 4);

        // Double buffer with prescale 7.
        prescale = 7;
        n = 0;
        while (m_pcnt != 0 && n < 20) begin cyc(); n++; end
        wr(0, 8'h00); wr(1, 8'hFF); wr(2, 8'h00); wr(3, 8'h80);
        count_ticks(100);
        chk("db_hold_ch1", ones[1], 0);
        chk("db_hold_ch2", 32'(ones[2] >= 99), 1);
        n = 0;
        while (m_pcnt != 0 && n < 20) begin cyc(); n++; end
        update_req = 1;
        cyc();
        update_req = 0;
        chk("db_pending_set", 32'(update_pending), 1);
        n = 0;
        while (m_pcnt != 7 && n < 20) begin cyc(); n++; end
        wr_en = 1; wr_ch = 0; wr_data = 8'hFF;
        cyc();
        wr_en = 0;
        chk("db_commit_tick", 32'(tick), 1);
        chk("db_pending_clear", 32'(update_pending), 0);
        count_ticks(256);
        chk("db_ch0_old_shadow", ones[0], 0);
        chk("db_ch1", ones[1], 255);
        chk("db_ch2", ones[2], 0);
        chk("db_ch3", ones[3], 128);

        // Second order at quarter density.
        prescale = 0; mode = 1;
        for (int c = 0; c < C; c++) wr(c, 8'h40);
        commit_now();
        count_ticks(1024);
        chk("mode1_density", 32'(ones[0] >= 252 && ones[0] <= 260), 1);
        mode = 0;
        repeat (50) cyc();
        mode = 1;
        repeat (50) cyc();

        // Randomized traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2 reset = 1;
                #1;
                chk("rst_async_pdm_out", 32'(pdm_out), 0);
                chk("rst_async_tick", 32'(tick), 0);
                chk("rst_async_pending", 32'(update_pending), 0);
                cyc();
                reset = 0; enable = 1; prescale = 0; wr_en = 0; update_req = 0;
                cyc();
                chk("rst_first_tick", 32'(tick), 1);
            end
            enable = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ($urandom_range(0, 49) == 0) prescale = 8'($urandom_range(0, 3));
            wr_en = $urandom_range(0, 4) == 0;
            wr_ch = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            update_req = $urandom_range(0, 19) == 0;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
